// File: rtl/display_pkg.sv
// Shared types and constants for the BCD display controller and its converter.
// The leading-zero helper lives here so the blanking rule has a single definition.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int IDX_W      = 2;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  // True when digit idx is a leading zero: idx > 0 and digits idx..MSD are all zero.
  function automatic logic lz_blank(input digits_t d, input logic [IDX_W-1:0] idx);
    logic zero;
    zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (d[i] != 4'd0)) zero = 1'b0;
    end
    return (idx != '0) && zero;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter: one shift per cycle, BIN_W cycles per value.
// start is ignored while busy; done is high during the cycle of the final shift.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output digits_t          bcd
);

  logic [BIN_W-1:0] sh_bin;
  logic [3:0]       cnt;
  logic             run;
  digits_t          adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i] >= 4'd5) adj[i] = bcd[i] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      cnt    <= 4'd0;
      sh_bin <= '0;
      bcd    <= '0;
    end else if (start && !run) begin
      run    <= 1'b1;
      cnt    <= 4'd0;
      sh_bin <= bin_in;
      bcd    <= '0;
    end else if (run) begin
      {bcd, sh_bin} <= {adj, sh_bin} << 1;
      cnt           <= cnt + 4'd1;
      if (cnt == 4'(BIN_W - 1)) run <= 1'b0;
    end
  end

  assign busy = run;
  assign done = run && (cnt == 4'(BIN_W - 1));

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Converts a binary value to four BCD digits and scans them onto one shared seven-segment decoder.
// load accepted only when idle (15-cycle conversion, 1-cycle overflow path); loads while busy are dropped.
module bcd_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int MAX_VAL  = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      value,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [3:0]            hex_out,
  output logic [NUM_DIGITS-1:0] digit_en_n
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

  logic [1:0]       state;
  logic             ovf_arm;
  digits_t          digits;
  logic             value_ovf;
  logic             start;
  logic             conv_busy;
  logic             conv_done;
  digits_t          conv_bcd;

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  logic             commit_now;
  digits_t          disp;
  logic             ovf_now;

  assign value_ovf = (value > MAX_V);
  assign start     = (state == ST_IDLE) && load && !value_ovf;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (value),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ovf_arm  <= 1'b0;
      overflow <= 1'b0;
      digits   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            ovf_arm <= value_ovf;
            state   <= value_ovf ? ST_COMMIT : ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (conv_done) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          overflow <= ovf_arm;
          if (!ovf_arm) digits <= conv_bcd;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE) || conv_busy;
  assign done = (state == ST_COMMIT);

  // A slot starting on the commit edge must already show the new digits.
  assign commit_now = (state == ST_COMMIT);
  assign disp       = (commit_now && !ovf_arm) ? conv_bcd : digits;
  assign ovf_now    = commit_now ? ovf_arm : overflow;

  // Outputs are latched once per slot, so a slot never mixes old and new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      digit_en_n <= 4'b1110;
      hex_out    <= 4'h0;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (presc == '0) begin
        digit_en_n <= ~(NUM_DIGITS'(1) << idx);
        hex_out    <= (ovf_now || (blank_lz && lz_blank(disp, idx))) ? BLANK_CODE : disp[idx];
      end
    end
  end

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Controller that turns a binary count into four BCD digits and time-multiplexes them onto one shared 4-bit hex-to-seven-segment decoder driving a common-segment, 4-digit display. The binary-to-BCD conversion is sequential (shift-and-add-3), and a load/busy/done handshake accepts new values. Leading-zero blanking and overflow blanking work by sending 4'hF, which the decoder renders as all segments off. The block sits between the counter/score datapath and the decoder instance.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot. Must be ≥ 2; use 4 in simulation.
- `MAX_VAL`, 9999: largest displayable value. Fixed to the 4-digit range.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `value` input 14: unsigned binary value to display.
- `load` input 1: request to convert `value`; sampled only when `busy`=0.
- `blank_lz` input 1: 1 = blank leading zeros. Sampled live by the scanner.
- `busy` output 1: conversion in progress; `load` is ignored while it is high.
- `done` output 1: one-cycle pulse when new digits are committed to the display.
- `overflow` output 1: sticky; set when the last accepted `value` is > `MAX_VAL`.
- `hex_out` output 4: digit code to the shared decoder; 4'hF = blank.
- `digit_en_n` output 4: active-low one-hot digit select; bit 0 = least-significant digit.

## Operation
- **FSM states:** IDLE, CONVERT, COMMIT.
- **IDLE:**
  - `load`=1 and `value` ≤ 9999: capture `value` into the shift register, clear the BCD accumulator, set the iteration counter to 0, go to CONVERT.
  - `load`=1 and `value` > 9999: go straight to COMMIT with the overflow flag armed.
- **CONVERT:** each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. After the 14th shift (counter = 13), go to COMMIT.
- **COMMIT:**
  - Copy the accumulator to the four display-digit registers in one cycle, so the update is atomic.
  - `overflow` takes the armed flag, set or cleared.
  - Pulse `done`, return to IDLE.
  - On overflow the display-digit registers are left unchanged and all digits are forced blank while `overflow`=1.
- **Displayed digits:** the old digits stay on display throughout CONVERT.
- **Scanner:** runs continuously and independently of the FSM.
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- **Blanking rule for digit i:**
  - Blank if `overflow`=1.
  - Blank if `blank_lz`=1, i > 0, and digits i..3 are all zero.
  - Digit 0 is never blanked by the leading-zero rule.
- **Outputs:** `hex_out` and `digit_en_n` are registered from the digit index and blanking result, so they never glitch.
- **Reset values:** state IDLE; `busy`=0, `done`=0, `overflow`=0; digit registers 0; prescaler 0; index 0; `digit_en_n`=4'b1110; `hex_out`=4'h0.

## Timing
- **Load latency:** `load` sampled high at edge N.
  - `busy`=1 from N+1 through N+15.
  - Digits are committed and `done`=1 during cycle N+15.
  - `busy`=0 again at N+16.
  - A new `load` is accepted at edge N+16 at the earliest.
- **Overflow path:** `busy` is high for one cycle only, and `done` pulses at N+1.
- **Load while busy:** dropped; no queueing.
- **Digit slot:** each digit is enabled for exactly `SCAN_DIV` cycles. Full refresh period = 4×`SCAN_DIV`.
- **Output register delay:** `digit_en_n` and `hex_out` change together, one cycle after the prescaler wraps.
- **COMMIT coinciding with a scan step:** the scanner shows the new digit value in the slot that starts that cycle; there is no mixed old/new frame within a slot.
- **Reset mid-conversion:** asynchronous return to the reset values above. The partial result is discarded.

## Structure
- **Shared package** (`display_pkg`):
  - FSM state encoding.
  - `BLANK_CODE` = 4'hF.
  - `NUM_DIGITS` = 4.
  - `BIN_W` = 14.
- **Sub-module:** `bin2bcd_seq`, holding the CONVERT datapath (shift register, add-3 logic, iteration counter) with `start`/`busy`/`done`.
  - The FSM and scanner stay in the top block.
  - The decoder is instantiated outside this block.

## Test plan
- **Reset:** assert `rst` mid-run → `digit_en_n`=4'b1110, `hex_out`=0, `busy`=0, `overflow`=0 immediately, without waiting for a clock edge.
- **Conversion:** load 1234 (`SCAN_DIV`=4) → `done` at +15 cycles. Over one refresh, `hex_out` sequence is 4,3,2,1 with `digit_en_n` 1110, 1101, 1011, 0111.
- **Leading-zero blanking:** load 7 with `blank_lz`=1 → scan shows 7,F,F,F. With `blank_lz`=0 → 7,0,0,0. Load 0 with `blank_lz`=1 → 0,F,F,F.
- **Overflow:** load 10000 → `done` at +1, `overflow`=1, all four slots show F. Then load 9999 → `overflow`=0, scan shows 9,9,9,9.
- **Load while busy:** load 42, then pulse load 77 at +5 → only 42 is displayed and only one `done` pulse occurs. Load 77 at +16 → accepted.
- **Wrap-around:** 20 consecutive refresh periods → each slot lasts exactly 4 cycles and the index wraps 3→0 without skipping.
